// File: rtl/cond_pkg.sv
// Shared condition-code encodings and flag bit positions for the ARM datapath.
// Pure declarations, no logic.
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purpose: evaluate a 4-bit ARM condition field against {N,Z,C,V}.
// Latency: purely combinational.
// Backpressure: none.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            EQ:      cond_ex = z;
            NE:      cond_ex = ~z;
            CS:      cond_ex = c;
            CC:      cond_ex = ~c;
            MI:      cond_ex = n;
            PL:      cond_ex = ~n;
            VS:      cond_ex = v;
            VC:      cond_ex = ~v;
            HI:      cond_ex = c & ~z;
            LS:      cond_ex = ~c | z;
            GE:      cond_ex = (n == v);
            LT:      cond_ex = (n != v);
            GT:      cond_ex = ~z & (n == v);
            LE:      cond_ex = z | (n != v);
            // NV is deliberately treated as always-execute
            default: cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Purpose: flags register, latched condition result, write-strobe gating, skip counter.
// Latency: flags and condition result registered (visible next cycle); strobes combinational from condex_q.
// Backpressure: none; strobes are level-gated, reset forces them low.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             cond_ld,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] skip_cnt
);

    logic [3:0]       flags_q, flags_d;
    logic             condex_q, condex_d;
    logic [CNT_W-1:0] skip_q, skip_d;
    logic             cond_ex;

    // Decision always uses the stored flags, so a same-cycle flag write cannot affect it
    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_q),
        .cond_ex (cond_ex)
    );

    always_comb begin
        flags_d  = flags_q;
        condex_d = condex_q;
        skip_d   = skip_q;
        if (FlagW[FLAGW_NZ] && cond_ex) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (FlagW[FLAGW_CV] && cond_ex) begin
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
        end
        if (cond_ld) begin
            condex_d = cond_ex;
            if (!cond_ex && (skip_q != {CNT_W{1'b1}})) begin
                skip_d = skip_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
            skip_q   <= '0;
        end else begin
            flags_q  <= flags_d;
            condex_q <= condex_d;
            skip_q   <= skip_d;
        end
    end

    // reset_n gates NextPC too, so the PC cannot advance while reset is held
    assign PCWrite  = reset_n & ((PCS & condex_q) | NextPC);
    assign RegWrite = reset_n & RegW & condex_q;
    assign MemWrite = reset_n & MemW & condex_q;
    assign Flags    = flags_q;
    assign skip_cnt = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: reset, flag groups, decode sweep, hazards, saturation.
module tb_cond_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       cond_ld, PCS, NextPC, RegW, MemW;
    logic       PCWrite, RegWrite, MemWrite;
    logic [3:0] Flags;
    logic [3:0] skip_cnt;

    int n_checks = 0;
    int n_bad    = 0;

    typedef struct {
        logic [3:0]  cond;
        logic [15:0] mask;   // bit f set when cond passes for flags value f = {N,Z,C,V}
    } vec_t;

    vec_t tbl[16];

    cond_unit #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .cond_ld  (cond_ld),
        .PCS      (PCS),
        .NextPC   (NextPC),
        .RegW     (RegW),
        .MemW     (MemW),
        .PCWrite  (PCWrite),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .Flags    (Flags),
        .skip_cnt (skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Cond = 4'hE; ALUFlags = 4'h0; FlagW = 2'b00; cond_ld = 1'b0;
        PCS = 1'b0; NextPC = 1'b0; RegW = 1'b0; MemW = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = f; cond_ld = 1'b0;
        tick();
        FlagW = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        #2;
        tick();
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        tbl[0]  = '{4'h0, 16'hF0F0};
        tbl[1]  = '{4'h1, 16'h0F0F};
        tbl[2]  = '{4'h2, 16'hCCCC};
        tbl[3]  = '{4'h3, 16'h3333};
        tbl[4]  = '{4'h4, 16'hFF00};
        tbl[5]  = '{4'h5, 16'h00FF};
        tbl[6]  = '{4'h6, 16'hAAAA};
        tbl[7]  = '{4'h7, 16'h5555};
        tbl[8]  = '{4'h8, 16'h0C0C};
        tbl[9]  = '{4'h9, 16'hF3F3};
        tbl[10] = '{4'hA, 16'hAA55};
        tbl[11] = '{4'hB, 16'h55AA};
        tbl[12] = '{4'hC, 16'h0A05};
        tbl[13] = '{4'hD, 16'hF5FA};
        tbl[14] = '{4'hE, 16'hFFFF};
        tbl[15] = '{4'hF, 16'hFFFF};

        // Reset held with strobe requests active
        idle();
        reset_n = 1'b0;
        NextPC = 1'b1; RegW = 1'b1; MemW = 1'b1; PCS = 1'b1;
        #12;
        check("rst_pcwrite", PCWrite, 0);
        check("rst_regwrite", RegWrite, 0);
        check("rst_memwrite", MemWrite, 0);
        check("rst_flags", Flags, 0);
        check("rst_skip", skip_cnt, 0);
        tick();
        check("rst_pcwrite_edge", PCWrite, 0);
        idle();
        reset_n = 1'b1;
        tick();

        // Failed instruction: no flag write, counter bumps, strobes suppressed
        Cond = 4'h0; FlagW = 2'b11; ALUFlags = 4'b0100; cond_ld = 1'b1;
        tick();
        idle();
        check("fail_flags", Flags, 4'b0000);
        check("fail_skip", skip_cnt, 1);
        MemW = 1'b1; PCS = 1'b1; #1;
        check("fail_memwrite", MemWrite, 0);
        check("fail_pcwrite", PCWrite, 0);
        NextPC = 1'b1; #1;
        check("nextpc_pcwrite", PCWrite, 1);
        idle();

        // Flag group independence
        Cond = 4'hE; ALUFlags = 4'b1111; FlagW = 2'b10;
        tick();
        check("grp_nz", Flags, 4'b1100);
        FlagW = 2'b01; ALUFlags = 4'b0011;
        tick();
        check("grp_cv", Flags, 4'b1111);
        idle();

        // Same-cycle hazard: decision on old Z=0, flags update alongside
        set_flags(4'b0000);
        Cond = 4'h1; FlagW = 2'b10; ALUFlags = 4'b0100; cond_ld = 1'b1;
        tick();
        idle();
        check("haz_flags", Flags, 4'b0100);
        RegW = 1'b1; PCS = 1'b1; MemW = 1'b1; #1;
        check("haz_regwrite", RegWrite, 1);
        check("haz_pcwrite", PCWrite, 1);
        check("haz_memwrite", MemWrite, 1);

        // Reset mid-instruction clears condex_q asynchronously
        NextPC = 1'b1;
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_regwrite", RegWrite, 0);
        check("midrst_pcwrite", PCWrite, 0);
        check("midrst_flags", Flags, 0);
        tick();
        reset_n = 1'b1;
        NextPC = 1'b0;
        tick();
        check("postrst_regwrite", RegWrite, 0);
        check("postrst_memwrite", MemWrite, 0);
        idle();

        // Full decode sweep
        for (int f = 0; f < 16; f++) begin
            for (int i = 0; i < 16; i++) begin
                set_flags(4'(f));
                if (i == 0) check($sformatf("sweep_flags f=%0d", f), Flags, 32'(f));
                Cond = tbl[i].cond; cond_ld = 1'b1; RegW = 1'b1; FlagW = 2'b00;
                tick();
                cond_ld = 1'b0;
                #1;
                check($sformatf("decode f=%0d c=%0d", f, i), RegWrite, 32'(tbl[i].mask[f]));
            end
        end
        idle();

        // Counter saturation with a 4-bit counter
        do_reset();
        check("sat_start", skip_cnt, 0);
        Cond = 4'h0; cond_ld = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 3) check("sat_k3", skip_cnt, 3);
            if (k == 15) check("sat_k15", skip_cnt, 15);
            if (k == 16) check("sat_k16", skip_cnt, 15);
        end
        check("sat_k20", skip_cnt, 15);
        Cond = 4'hE;
        tick();
        check("sat_pass_hold", skip_cnt, 15);
        idle();
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
